// File: rtl/oam_dma_if.sv
// oam_dma_if: bus bundle between the OAM DMA engine and the CPU, memory and PPU register port.
// Latency: none; this is wiring only, and every timing property comes from the engine.
// Backpressure: none on this bundle; the engine stalls the CPU through cpu_halt.
interface oam_dma_if;
  // CPU register-write snoop
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_write;
  logic        cpu_halt;
  // Source memory read port
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [7:0]  mem_din;
  // PPU register write port
  logic [2:0]  ppu_ain;
  logic        ppu_write;
  logic [7:0]  ppu_din;

  // DMA engine side
  modport master (
    input  cpu_addr, cpu_dout, cpu_write, mem_din,
    output cpu_halt, mem_addr, mem_read, ppu_ain, ppu_write, ppu_din
  );

  // CPU / memory / PPU side
  modport slave (
    output cpu_addr, cpu_dout, cpu_write, mem_din,
    input  cpu_halt, mem_addr, mem_read, ppu_ain, ppu_write, ppu_din
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: a CPU write of page XX to DMA_REG copies CPU bytes $XX00-$XXFF into PPU register OAM_REG.
// Latency: halt rises one CPU cycle after the trigger; each byte takes one READ and one WRITE CPU cycle (513/514 total).
// Backpressure: none accepted; the CPU is stalled via cpu_halt, and all progress is paced by i_ce.
// Build option: define OAM_DMA_ALIGN_EN to insert the ALIGN cycle when HALT lands on an odd CPU cycle.
module oam_dma #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter logic [2:0]  OAM_REG = 3'd4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_ce,
  oam_dma_if.master io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic        r_halt;
  logic        r_rd_arm;
  logic        r_wr_arm;
  logic [15:0] r_mem_addr;
  logic [2:0]  r_ppu_ain;
  // Holds the byte fetched in READ; it is only ever visible while in WRITE.
  logic [7:0]  r_ppu_din;

  logic        w_trigger;
  logic        w_last;
  logic [7:0]  w_idx_next;

  assign w_trigger  = io_bus.cpu_write && (io_bus.cpu_addr == DMA_REG);
  assign w_last     = (r_idx == 8'hFF);
  assign w_idx_next = r_idx + 8'd1;

`ifdef OAM_DMA_ALIGN_EN
  logic r_parity;

  // CPU-cycle parity: flips on every CPU cycle, decides whether HALT needs an ALIGN cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_parity <= 1'b0;
    end else if (i_ce) begin
      r_parity <= ~r_parity;
    end
  end
`endif

  // Transfer FSM; outputs are registered alongside the state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_page     <= 8'h00;
      r_idx      <= 8'h00;
      r_halt     <= 1'b0;
      r_rd_arm   <= 1'b0;
      r_wr_arm   <= 1'b0;
      r_mem_addr <= 16'h0000;
      r_ppu_ain  <= 3'd0;
      r_ppu_din  <= 8'h00;
    end else if (i_ce) begin
      case (r_state)
        ST_IDLE: begin
          // Only an idle engine accepts a trigger; the page is latched here and nowhere else.
          if (w_trigger) begin
            r_page  <= io_bus.cpu_dout;
            r_idx   <= 8'h00;
            r_halt  <= 1'b1;
            r_state <= ST_HALT;
          end
        end

        ST_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          if (r_parity) begin
            r_state <= ST_ALIGN;
          end else begin
            r_state    <= ST_READ;
            r_mem_addr <= {r_page, r_idx};
            r_rd_arm   <= 1'b1;
          end
`else
          r_state    <= ST_READ;
          r_mem_addr <= {r_page, r_idx};
          r_rd_arm   <= 1'b1;
`endif
        end

        ST_ALIGN: begin
          r_state    <= ST_READ;
          r_mem_addr <= {r_page, r_idx};
          r_rd_arm   <= 1'b1;
        end

        ST_READ: begin
          // mem_din is valid in this same CPU cycle; capture it for the WRITE that follows.
          r_ppu_din  <= io_bus.mem_din;
          r_ppu_ain  <= OAM_REG;
          r_wr_arm   <= 1'b1;
          r_rd_arm   <= 1'b0;
          r_mem_addr <= 16'h0000;
          r_state    <= ST_WRITE;
        end

        ST_WRITE: begin
          // idx wraps to 0 only after the 256th write, so the address never leaves the page.
          r_idx     <= w_idx_next;
          r_wr_arm  <= 1'b0;
          r_ppu_ain <= 3'd0;
          r_ppu_din <= 8'h00;
          if (w_last) begin
            r_halt  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_mem_addr <= {r_page, w_idx_next};
            r_rd_arm   <= 1'b1;
            r_state    <= ST_READ;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_halt     <= 1'b0;
          r_rd_arm   <= 1'b0;
          r_wr_arm   <= 1'b0;
          r_mem_addr <= 16'h0000;
          r_ppu_ain  <= 3'd0;
          r_ppu_din  <= 8'h00;
        end
      endcase
    end
  end

  // Strobes are gated by i_ce so a multi-clk CPU cycle produces exactly one pulse.
  assign io_bus.mem_read  = r_rd_arm & i_ce;
  assign io_bus.ppu_write = r_wr_arm & i_ce;

  assign io_bus.cpu_halt  = r_halt;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.ppu_ain   = r_ppu_ain;
  assign io_bus.ppu_din   = r_ppu_din;

endmodule
